// File: rtl/shift_left_seq_unit.sv
// Iterative left shift / rotate unit: one bit position per clock, start/done handshake.
// Latency: DONE is high in the cycle after edge AMOUNT+1, counted from the accepting edge.
// Backpressure: START is taken only in IDLE or DONE. BUSY is high during SHIFT, and requests made then are dropped.
//
// Optional feature: define SHIFT_ZERO_FLAG_EN to add the registered ZERO output (zero_o).
// Ports:
//   clk_i, rst_i               clock and asynchronous active-high reset
//   start_i                    request, sampled in IDLE or DONE only
//   operand_i, amount_i        value and shift count, captured on the accepting edge
//   mode_i                     0 = logical shift left (zero fill), 1 = rotate left
//   busy_o, done_o             BUSY while shifting; one-cycle DONE pulse
//   result_o, carry_o          result and last bit shifted out of the MSB, held until the next DONE
//   zero_o                     (SHIFT_ZERO_FLAG_EN only) result == 0, updated with result_o
module shift_left_seq_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             mode_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
`ifdef SHIFT_ZERO_FLAG_EN
  ,
  output logic             zero_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             carry_w_q, carry_w_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
`ifdef SHIFT_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      carry_w_q <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
`ifdef SHIFT_ZERO_FLAG_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      carry_w_q <= carry_w_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
`ifdef SHIFT_ZERO_FLAG_EN
      zero_q    <= zero_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    carry_w_d = carry_w_q;
    result_d  = result_q;
    carry_d   = carry_q;
`ifdef SHIFT_ZERO_FLAG_EN
    zero_d    = zero_q;
`endif
    case (state_q)
      // DONE accepts a new request exactly as IDLE does, which gives back-to-back operation.
      S_IDLE, S_DONE: begin
        if (start_i) begin
          work_d    = operand_i;
          cnt_d     = amount_i;
          mode_d    = mode_i;
          carry_w_d = 1'b0;
          state_d   = S_SHIFT;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          // In rotate mode the fill bit is the outgoing MSB. That bit is also the carry.
          carry_w_d = work_q[WIDTH-1];
          work_d    = {work_q[WIDTH-2:0], mode_q & work_q[WIDTH-1]};
          cnt_d     = cnt_q - AMT_W'(1);
        end else begin
          result_d  = work_q;
          carry_d   = carry_w_q;
`ifdef SHIFT_ZERO_FLAG_EN
          zero_d    = (work_q == '0);
`endif
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o   = (state_q == S_SHIFT);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign carry_o  = carry_q;
`ifdef SHIFT_ZERO_FLAG_EN
  assign zero_o   = zero_q;
`endif

endmodule

// File: tb/tb_shift_left_seq_unit.sv
// Bench for shift_left_seq_unit: directed cases plus randomized operations.
// Expected values come from an arithmetic model of shift/rotate.
// The bench drives inputs and samples outputs 1 ns after each rising edge.
module tb_shift_left_seq_unit;

  logic       clk_i;
  logic       rst_i;
  logic       start_i;
  logic [7:0] operand_i;
  logic [2:0] amount_i;
  logic       mode_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] result_o;
  logic       carry_o;
`ifdef SHIFT_ZERO_FLAG_EN
  logic       zero_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  shift_left_seq_unit #(.WIDTH(8), .AMT_W(3)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .operand_i (operand_i),
    .amount_i  (amount_i),
    .mode_i    (mode_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .carry_o   (carry_o)
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    .zero_o    (zero_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model. It computes a rotate from a doubled operand and a logical shift
  // from a zero-extended operand. The carry is the last bit that crosses the MSB.
  task automatic model(input logic [7:0] op, input logic [2:0] amt, input logic md,
                       output logic [7:0] res, output logic cy);
    logic [15:0] t;
    if (md) begin
      t   = {op, op} << amt;
      res = t[15:8];
      cy  = (amt == 3'd0) ? 1'b0 : op[8 - int'(amt)];
    end else begin
      t   = {8'h00, op} << amt;
      res = t[7:0];
      cy  = t[8];
    end
  endtask

  // Waits for DONE. It counts edges from the accepting edge, checks BUSY and
  // the held RESULT on the way, and stops after a fixed cycle budget.
  task automatic wait_done(input int lat0, input logic [7:0] hold_r, output int lat);
    lat = lat0;
    while (!done_o && lat < 20) begin
      chk("busy_during_shift", busy_o, 1'b1);
      chk("result_held", result_o, hold_r);
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic check_done(input logic [7:0] op, input logic [2:0] amt, input logic md, input int lat);
    logic [7:0] er;
    logic       ec;
    model(op, amt, md, er, ec);
    chk("latency", lat, int'(amt) + 1);
    chk("done", done_o, 1'b1);
    chk("busy_at_done", busy_o, 1'b0);
    chk("result", result_o, er);
    chk("carry", carry_o, ec);
`ifdef SHIFT_ZERO_FLAG_EN
    chk("zero", zero_o, (er == 8'h00));
`endif
  endtask

  // Runs one full operation. It is called 1 ns after an edge with the unit in IDLE.
  task automatic run_op(input logic [7:0] op, input logic [2:0] amt, input logic md);
    logic [7:0] hold_r;
    int lat;
    hold_r    = result_o;
    start_i   = 1'b1;
    operand_i = op;
    amount_i  = amt;
    mode_i    = md;
    @(posedge clk_i); #1;
    start_i   = 1'b0;
    // Scramble the data inputs. This must not disturb the operation in flight.
    operand_i = 8'($urandom);
    amount_i  = 3'($urandom);
    mode_i    = 1'($urandom);
    wait_done(0, hold_r, lat);
    check_done(op, amt, md, lat);
    @(posedge clk_i); #1;
    chk("done_pulse_width", done_o, 1'b0);
  endtask

  initial begin
    int lat;
    int extra_done;
    start_i   = 1'b0;
    operand_i = 8'h00;
    amount_i  = 3'd0;
    mode_i    = 1'b0;
    rst_i     = 1'b1;
    #2;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_result", result_o, 8'h00);
    chk("rst_carry", carry_o, 1'b0);
`ifdef SHIFT_ZERO_FLAG_EN
    chk("rst_zero", zero_o, 1'b0);
`endif
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed cases.
    run_op(8'h81, 3'd1, 1'b0);
    run_op(8'h81, 3'd3, 1'b1);
    run_op(8'hA5, 3'd0, 1'b0);
    run_op(8'h80, 3'd1, 1'b0);

    // A START pulse while BUSY is ignored. Only one DONE follows.
    start_i = 1'b1; operand_i = 8'hFF; amount_i = 3'd7; mode_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1; operand_i = 8'h01; amount_i = 3'd0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(2, 8'h00, lat);
    check_done(8'hFF, 3'd7, 1'b0, lat);
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) extra_done++;
    end
    chk("no_second_done", extra_done, 0);

    // Back-to-back operation: START is held high through the DONE cycle.
    start_i = 1'b1; operand_i = 8'h81; amount_i = 3'd1; mode_i = 1'b0;
    @(posedge clk_i); #1;
    operand_i = 8'h01; amount_i = 3'd2; mode_i = 1'b0;
    wait_done(0, 8'h80, lat);
    check_done(8'h81, 3'd1, 1'b0, lat);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("b2b_accept_busy", busy_o, 1'b1);
    wait_done(0, 8'h02, lat);
    check_done(8'h01, 3'd2, 1'b0, lat);
    @(posedge clk_i); #1;

    // Reset during an operation aborts it at once.
    start_i = 1'b1; operand_i = 8'h81; amount_i = 3'd5; mode_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_done", done_o, 1'b0);
    chk("abort_result", result_o, 8'h00);
    chk("abort_carry", carry_o, 1'b0);
`ifdef SHIFT_ZERO_FLAG_EN
    chk("abort_zero", zero_o, 1'b0);
`endif
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) extra_done++;
    end
    chk("no_done_after_abort", extra_done, 0);
    run_op(8'h3C, 3'd2, 1'b1);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
